sample_buffer: RTL and testbench
================================

SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning FIFO entries; must be a power of two, 4..1024.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning log2(DEPTH).
REQ-003 SHALL have port clock_i  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port comm_i  input  32  peripheral comm word: [23] clear pulse, [22] pop request, [21] capture enable.
REQ-006 SHALL have port phase_i  input  32  core phase word; [31] is a one-cycle phase-change pulse, [30:0] is the phase id.
REQ-007 SHALL have port sample_valid_i  input  1  cache sample strobe.
REQ-008 SHALL have port sample_i  input  32  cache sample payload.
REQ-009 SHALL have port status_o  output  32  registered status word; feeds the comm_cache0 read path.
REQ-010 SHALL have port data_o  output  32  registered head entry; feeds the comm_cache1 read path.
REQ-011 SHALL have port full_o  output  1  registered, high when count equals DEPTH.

Function
REQ-012 SHALL implement a DEPTH x 32 circular FIFO with rd_ptr/wr_ptr of ADDR_W bits that wrap modulo DEPTH, and a count of ADDR_W+1 bits.
REQ-013 SHALL have FSM states IDLE=2'd0, CAPTURE=2'd1 and FULL=2'd2.
REQ-014 FSM transitions SHALL be: IDLE->CAPTURE when comm_i[21]=1; CAPTURE->IDLE when comm_i[21]=0; CAPTURE->FULL when a write makes count equal DEPTH; FULL->CAPTURE or IDLE (per comm_i[21]) after any pop or clear.
REQ-015 A write SHALL occur only in CAPTURE with sample_valid_i=1; the write takes one cycle and count/full_o update on the next edge.
REQ-016 In FULL, each sample_valid_i SHALL be dropped and SHALL increment an 8-bit drop counter that saturates at 8'hFF.
REQ-017 A pop SHALL be the rising edge of comm_i[22] (registered previous value compared with the current value); each edge pops at most one entry, and a held-high level SHALL NOT pop repeatedly.
REQ-018 A pop on an empty FIFO SHALL be ignored, with no pointer, count or flag change.
REQ-019 A simultaneous write and pop on a non-empty FIFO SHALL advance both pointers and leave count unchanged.
REQ-020 A simultaneous write and pop on an empty FIFO SHALL perform the write only.
REQ-021 comm_i[23]=1 SHALL, on that edge, zero both pointers, count, the drop counter and the overflow flag, and set state per comm_i[21]; clear has priority over a write or pop in the same cycle.
REQ-022 data_o SHALL be registered each cycle as mem[rd_ptr] when count!=0, else 32'h0; it therefore lags any pointer or count change by one cycle.
REQ-023 status_o SHALL be registered as {state[1:0], overflow, 5'b0, drop_cnt[7:0], count zero-extended to 16 bits}.
REQ-024 overflow SHALL be set by the first dropped sample and SHALL be cleared only by clear or reset.

Reset
REQ-025 When reset_i=0 at a clock edge: state=IDLE, pointers=0, count=0, drop_cnt=0, overflow=0, pop-edge register=0, status_o=32'h0, data_o=32'h0, full_o=0.
REQ-026 Reset mid-operation SHALL discard all contents; memory contents need not be cleared, and data_o reads as 0 while count is 0.

Configuration
REQ-027 With macro SAMPLER_PHASE_TAG_EN defined: in CAPTURE, phase_i[31]=1 SHALL write the marker entry {1'b1, phase_i[30:0]}.
REQ-028 With SAMPLER_PHASE_TAG_EN defined: samples SHALL be stored as {1'b0, sample_i[30:0]}.
REQ-029 With SAMPLER_PHASE_TAG_EN defined: a marker SHALL win over a same-cycle sample, and that sample SHALL be counted as dropped.
REQ-030 With SAMPLER_PHASE_TAG_EN defined: a marker arriving in FULL SHALL be dropped and counted like a sample.
REQ-031 Without SAMPLER_PHASE_TAG_EN: phase_i SHALL be ignored and samples SHALL be stored as the full 32 bits.

Verification
REQ-032 Reset, then enable capture, then write 3 samples (0x11, 0x22, 0x33) -> status_o[15:0]=3, status_o[31:30]=2'd1, and data_o=0x11 one cycle after the first write lands.
REQ-033 Write DEPTH samples, then 2 more -> full_o=1, state=FULL, drop_cnt=2, overflow=1; then one pop -> count=DEPTH-1 and state=CAPTURE.
REQ-034 Write and pop in the same cycle at count=5 -> count stays 5 and data_o advances to the next entry; a pop at count=0 -> no change.
REQ-035 Pulse clear together with sample_valid_i and a pop edge -> all counters 0, no entry written, data_o=0 next cycle.
REQ-036 With SAMPLER_PHASE_TAG_EN: phase_i=0x80000007 with sample 0x55 in the same cycle -> entry 0x80000007 stored and drop_cnt=1; without the macro -> entry 0x55 stored.
REQ-037 Hold comm_i[22] high for 4 cycles with count=3 -> exactly one pop, count=2.

Source files
------------

// File: rtl/sample_buffer.sv
// sample_buffer: 32-bit sample FIFO with capture FSM, pop-edge detection and drop accounting.
// Optional macro SAMPLER_PHASE_TAG_EN stores phase-change markers inline with the samples.
//
// state   | meaning
// IDLE    | capture disabled, samples ignored, pops still drain the FIFO
// CAPTURE | capture enabled, valid samples are written
// FULL    | count == DEPTH, incoming samples/markers are dropped and counted
module sample_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] comm_i,
  input  logic [31:0] phase_i,
  input  logic        sample_valid_i,
  input  logic [31:0] sample_i,
  output logic [31:0] status_o,
  output logic [31:0] data_o,
  output logic        full_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [31:0]     mem [DEPTH];

  state_t          state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [7:0]      drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic            pop_prev_q;
  logic [31:0]     status_q, status_d;
  logic [31:0]     data_q, data_d;
  logic            full_q, full_d;

  logic            clear, cap_en, pop_edge, marker;
  logic            fifo_empty, fifo_full, wr_en, pop_en;
  logic [1:0]      drop_n;
  logic [8:0]      drop_sum;
  logic [31:0]     wr_data;
  logic            unused_bits;

  assign unused_bits = ^{comm_i[31:24], comm_i[20:0], phase_i};

  always_comb begin
    clear      = comm_i[23];
    cap_en     = comm_i[21];
    pop_edge   = comm_i[22] & ~pop_prev_q;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
`ifdef SAMPLER_PHASE_TAG_EN
    marker  = phase_i[31];
    wr_data = marker ? {1'b1, phase_i[30:0]} : {1'b0, sample_i[30:0]};
`else
    marker  = 1'b0;
    wr_data = sample_i;
`endif

    wr_en  = !clear && (state_q == CAPTURE) && (sample_valid_i || marker) && !fifo_full;
    pop_en = !clear && pop_edge && !fifo_empty;

    // A marker displaces a same-cycle sample; in FULL everything arriving is lost.
    drop_n = 2'd0;
    if (state_q == FULL)
      drop_n = {1'b0, sample_valid_i} + {1'b0, marker};
    else if (state_q == CAPTURE && marker && sample_valid_i)
      drop_n = 2'd1;

    drop_sum = {1'b0, drop_q} + {7'b0, drop_n};

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    state_d  = state_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
      state_d  = cap_en ? CAPTURE : IDLE;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop_en)      count_d = count_q + 1'b1;
      else if (pop_en && !wr_en) count_d = count_q - 1'b1;
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      ovf_d  = ovf_q | (drop_n != 2'd0);

      // CAPTURE is only ever entered with room left, so writes never overrun.
      unique case (state_q)
        IDLE:    if (cap_en) state_d = (count_d == CNT_FULL) ? FULL : CAPTURE;
        CAPTURE: if (count_d == CNT_FULL) state_d = FULL;
                 else if (!cap_en)        state_d = IDLE;
        FULL:    if (pop_en) state_d = cap_en ? CAPTURE : IDLE;
        default: state_d = IDLE;
      endcase
    end

    data_d   = fifo_empty ? 32'h0 : mem[rd_ptr_q];
    status_d = {state_q, ovf_q, 5'b0, drop_q, {(15-ADDR_W){1'b0}}, count_q};
    full_d   = (count_d == CNT_FULL);
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
      pop_prev_q <= 1'b0;
      status_q   <= '0;
      data_q     <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      pop_prev_q <= comm_i[22];
      status_q   <= status_d;
      data_q     <= data_d;
      full_q     <= full_d;
    end
  end

  assign status_o = status_q;
  assign data_o   = data_q;
  assign full_o   = full_q;

endmodule

// File: tb/tb_sample_buffer.sv
// tb_sample_buffer: directed vectors for sample_buffer (DEPTH=8) with hand-computed expectations.
// Honours SAMPLER_PHASE_TAG_EN for the marker vector.
module tb_sample_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

`ifdef SAMPLER_PHASE_TAG_EN
  localparam logic [31:0] TAG_ENTRY = 32'h8000_0007;
  localparam logic [7:0]  TAG_DROP  = 8'd1;
  localparam logic        TAG_OVF   = 1'b1;
`else
  localparam logic [31:0] TAG_ENTRY = 32'h0000_0055;
  localparam logic [7:0]  TAG_DROP  = 8'd0;
  localparam logic        TAG_OVF   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap, pop, clr;
  logic [31:0] comm;
  logic [31:0] phase;
  logic        valid;
  logic [31:0] sample;
  logic [31:0] status;
  logic [31:0] data;
  logic        full;

  int checks = 0;
  int errors = 0;

  assign comm = {8'h0, clr, pop, cap, 21'h0};

  always #5 clk = ~clk;

  sample_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .comm_i        (comm),
    .phase_i       (phase),
    .sample_valid_i(valid),
    .sample_i      (sample),
    .status_o      (status),
    .data_o        (data),
    .full_o        (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic [1:0] st, input logic ovf,
                                       input logic [7:0] drop, input logic [15:0] cnt);
    return {st, ovf, 5'b0, drop, cnt};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    valid  = 1'b1;
    sample = v;
    step(1);
    valid  = 1'b0;
  endtask

  task automatic pop_once();
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; cap = 1'b0; pop = 1'b0; clr = 1'b0;
    phase = 32'h0; valid = 1'b0; sample = 32'h0;
    step(2);
    check("reset_status", status, 32'h0);
    check("reset_data", data, 32'h0);
    check("reset_full", {31'h0, full}, 32'h0);
    rst_n = 1'b1;

    // three samples; head appears one cycle after the first write lands
    cap = 1'b1;
    step(1);
    push(32'h11);
    push(32'h22);
    check("first_head", data, 32'h11);
    push(32'h33);
    step(1);
    check("three_status", status, stat(2'd1, 1'b0, 8'd0, 16'd3));

    // fill to DEPTH, then two drops
    for (int i = 4; i <= 8; i++) push(32'(i * 'h11));
    push(32'h91);
    push(32'h92);
    step(1);
    check("full_flag", {31'h0, full}, 32'h1);
    check("full_status", status, stat(2'd2, 1'b1, 8'd2, 16'd8));
    check("full_head", data, 32'h11);

    // one pop leaves FULL
    pop_once();
    check("pop_status", status, stat(2'd1, 1'b1, 8'd2, 16'd7));
    check("pop_head", data, 32'h22);
    check("pop_full", {31'h0, full}, 32'h0);

    // down to 5, then simultaneous write (wrapping to slot 0) and pop
    pop_once();
    pop_once();
    check("cnt5_status", status, stat(2'd1, 1'b1, 8'd2, 16'd5));
    check("cnt5_head", data, 32'h44);
    valid = 1'b1; sample = 32'h99; pop = 1'b1;
    step(1);
    valid = 1'b0; pop = 1'b0;
    step(1);
    check("wp_status", status, stat(2'd1, 1'b1, 8'd2, 16'd5));
    check("wp_head", data, 32'h55);

    // clear wins over same-cycle write and pop
    clr = 1'b1; valid = 1'b1; sample = 32'hDEAD_BEEF; pop = 1'b1;
    step(1);
    clr = 1'b0; valid = 1'b0; pop = 1'b0;
    step(1);
    check("clr_status", status, stat(2'd1, 1'b0, 8'd0, 16'd0));
    check("clr_data", data, 32'h0);
    check("clr_full", {31'h0, full}, 32'h0);

    // pop on empty is ignored, pointers stay put
    pop_once();
    check("empty_pop_status", status, stat(2'd1, 1'b0, 8'd0, 16'd0));
    push(32'hA1);
    step(1);
    check("after_empty_pop_head", data, 32'hA1);

    // phase marker together with a sample
    phase = 32'h8000_0007; valid = 1'b1; sample = 32'h55;
    step(1);
    phase = 32'h0; valid = 1'b0;
    pop_once();
    check("tag_entry", data, TAG_ENTRY);
    check("tag_status", status, stat(2'd1, TAG_OVF, TAG_DROP, 16'd1));

    // held pop level pops once
    push(32'hB1);
    push(32'hB2);
    pop = 1'b1;
    step(4);
    pop = 1'b0;
    step(1);
    check("held_pop_status", status, stat(2'd1, TAG_OVF, TAG_DROP, 16'd2));
    check("held_pop_head", data, 32'hB1);

    // capture off: IDLE ignores samples
    cap = 1'b0;
    step(1);
    push(32'hC1);
    step(1);
    check("idle_status", status, stat(2'd0, TAG_OVF, TAG_DROP, 16'd2));

    // reset mid-operation discards everything
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midreset_status", status, 32'h0);
    check("midreset_data", data, 32'h0);
    step(2);
    check("midreset_data_later", data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
